// File: rtl/maze_pkg.sv
// Shared constants and types for the maze access controller.
//   Screen geometry, player box geometry, colour codes, move direction
//   encoding, checker state encoding and the pixel index helper.
package maze_pkg;

    localparam int WIDTH   = 96;
    localparam int HEIGHT  = 64;
    localparam int PSIZE   = 3;
    localparam int STEP    = 1;
    localparam int START_X = 4;
    localparam int START_Y = 4;

    localparam logic [15:0] WALL_COLOUR = 16'hFFFF;
    localparam logic [15:0] GOAL_COLOUR = 16'h001F;
    localparam logic [15:0] PCOLOUR     = 16'hF800;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOUNDS = 3'd1,
        ST_PROBE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_REJECT = 3'd5
    } chk_state_t;

    // Linear ROM index of pixel (x,y); callers keep (x,y) on screen so it never wraps.
    function automatic logic [12:0] pix_idx(input logic [6:0] x, input logic [5:0] y);
        return 13'(y) * 13'(WIDTH) + 13'(x);
    endfunction

endpackage

// File: rtl/maze_pix_overlay.sv
// Display pipe: registers the requested index and composites the ROM pixel with
// the player box.
//   clk, reset          clock, asynchronous active-high reset
//   pix_req, pix_index  display request and index (cycle t0, sampled by the ROM too)
//   rom_data            ROM pixel for the t0 index, present in t1
//   player_x, player_y  player box top-left corner, used as seen in t1
//   pix_data, pix_valid composited pixel, valid in t2
module maze_pix_overlay
    import maze_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_req,
    input  logic [12:0] pix_index,
    input  logic [15:0] rom_data,
    input  logic [6:0]  player_x,
    input  logic [5:0]  player_y,
    output logic [15:0] pix_data,
    output logic        pix_valid
);

    logic        req_q, req_d;
    logic [12:0] idx_q, idx_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [12:0] base_s;
    logic [12:0] row_start_s;
    logic        inside_s;

    // Box hit test: the box never crosses the right screen edge, so each of its rows is
    // one contiguous index run starting at base + r*WIDTH.
    always_comb begin
        base_s      = pix_idx(player_x, player_y);
        row_start_s = base_s;
        inside_s    = 1'b0;
        for (int r = 0; r < PSIZE; r++) begin
            row_start_s = base_s + 13'(r * WIDTH);
            if ((idx_q >= row_start_s) && (idx_q < row_start_s + 13'(PSIZE))) begin
                inside_s = 1'b1;
            end else begin
                inside_s = inside_s;
            end
        end
    end

    // Next-state of the two pipe stages; pix_data holds between valid beats.
    always_comb begin
        req_d   = pix_req;
        idx_d   = pix_index;
        valid_d = req_q;
        data_d  = data_q;
        if (req_q) begin
            data_d = inside_s ? PCOLOUR : rom_data;
        end else begin
            data_d = data_q;
        end
    end

    // Pipe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q   <= 1'b0;
            idx_q   <= 13'd0;
            data_q  <= 16'd0;
            valid_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign pix_data  = data_q;
    assign pix_valid = valid_q;

endmodule

// File: rtl/maze_access_ctrl.sv
// Maze ROM port sharing between the OLED pixel requester and the player move checker.
//   Display requests always own the ROM port; the checker probes the leading edge of
//   the target box only in cycles without a display request.
//   clk, reset                         clock, asynchronous active-high reset
//   pix_req, pix_index / pix_data, pix_valid   display side
//   move_req, move_dir / move_busy, move_done, move_blocked   move side
//   player_x, player_y                 current box position
//   rom_index / rom_data               ROM port (1-cycle read latency)
//   goal_reached                       sticky goal flag
// Build option: define MAZE_GOAL_DETECT_EN to enable goal detection; otherwise
// goal_reached is tied low.
module maze_access_ctrl
    import maze_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_req,
    input  logic [12:0] pix_index,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        move_req,
    input  logic [1:0]  move_dir,
    output logic        move_busy,
    output logic        move_done,
    output logic        move_blocked,
    output logic [6:0]  player_x,
    output logic [5:0]  player_y,
    output logic [12:0] rom_index,
    input  logic [15:0] rom_data,
    output logic        goal_reached
);

    chk_state_t  state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [1:0]  k_q, k_d;
    logic [6:0]  px_q, px_d;
    logic [5:0]  py_q, py_d;
    logic        done_q, done_d;
    logic        blocked_q, blocked_d;
    logic [12:0] rom_index_q, rom_index_d;
    logic [6:0]  tx_s, probe_x_s;
    logic [5:0]  ty_s, probe_y_s;
    logic        in_bounds_s;
    logic        busy_s;
`ifdef MAZE_GOAL_DETECT_EN
    logic        goal_q, goal_d;
    logic        goal_seen_q, goal_seen_d;
`endif

    // Target position of the latched move and whether it stays on screen.
    always_comb begin
        tx_s        = px_q;
        ty_s        = py_q;
        in_bounds_s = 1'b1;
        case (dir_q)
            DIR_UP:    if (py_q < 6'(STEP)) in_bounds_s = 1'b0; else ty_s = py_q - 6'(STEP);
            DIR_DOWN:  if (py_q > 6'(HEIGHT - PSIZE - STEP)) in_bounds_s = 1'b0; else ty_s = py_q + 6'(STEP);
            DIR_LEFT:  if (px_q < 7'(STEP)) in_bounds_s = 1'b0; else tx_s = px_q - 7'(STEP);
            DIR_RIGHT: if (px_q > 7'(WIDTH - PSIZE - STEP)) in_bounds_s = 1'b0; else tx_s = px_q + 7'(STEP);
            default:   in_bounds_s = 1'b0;
        endcase
    end

    // k-th pixel on the leading edge of the target box.
    always_comb begin
        probe_x_s = tx_s;
        probe_y_s = ty_s;
        case (dir_q)
            DIR_UP:    probe_x_s = tx_s + 7'(k_q);
            DIR_DOWN: begin
                probe_x_s = tx_s + 7'(k_q);
                probe_y_s = ty_s + 6'(PSIZE - 1);
            end
            DIR_LEFT:  probe_y_s = ty_s + 6'(k_q);
            DIR_RIGHT: begin
                probe_x_s = tx_s + 7'(PSIZE - 1);
                probe_y_s = ty_s + 6'(k_q);
            end
            default:   probe_x_s = tx_s;
        endcase
    end

    // ROM port arbiter: display first, then a pending probe, else hold the last address.
    always_comb begin
        if (pix_req) begin
            rom_index_d = pix_index;
        end else if (state_q == ST_PROBE) begin
            rom_index_d = pix_idx(probe_x_s, probe_y_s);
        end else begin
            rom_index_d = rom_index_q;
        end
    end

`ifdef MAZE_GOAL_DETECT_EN
    assign busy_s = (state_q != ST_IDLE) || goal_q;
`else
    assign busy_s = (state_q != ST_IDLE);
`endif

    // Checker FSM next-state and pulse outputs.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        k_d       = k_q;
        px_d      = px_q;
        py_d      = py_q;
        done_d    = 1'b0;
        blocked_d = 1'b0;
`ifdef MAZE_GOAL_DETECT_EN
        goal_d      = goal_q;
        goal_seen_d = goal_seen_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (move_req && !busy_s) begin
                    dir_d   = dir_t'(move_dir);
                    state_d = ST_BOUNDS;
`ifdef MAZE_GOAL_DETECT_EN
                    goal_seen_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BOUNDS: begin
                if (!in_bounds_s) begin
                    state_d = ST_REJECT;
                end else begin
                    k_d     = 2'd0;
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: begin
                // The probe address only reaches the ROM in a cycle without a display request.
                if (!pix_req) state_d = ST_WAIT; else state_d = ST_PROBE;
            end
            ST_WAIT: begin
                if (rom_data == WALL_COLOUR) begin
                    state_d = ST_REJECT;
                end else begin
`ifdef MAZE_GOAL_DETECT_EN
                    if (rom_data == GOAL_COLOUR) goal_seen_d = 1'b1; else goal_seen_d = goal_seen_q;
`endif
                    k_d = k_q + 2'd1;
                    if (k_d == 2'(PSIZE)) state_d = ST_COMMIT; else state_d = ST_PROBE;
                end
            end
            ST_COMMIT: begin
                px_d    = tx_s;
                py_d    = ty_s;
                done_d  = 1'b1;
                state_d = ST_IDLE;
`ifdef MAZE_GOAL_DETECT_EN
                goal_d = goal_q | goal_seen_q;
`endif
            end
            ST_REJECT: begin
                blocked_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Checker state, position, pulses and held ROM address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_UP;
            k_q         <= 2'd0;
            px_q        <= 7'(START_X);
            py_q        <= 6'(START_Y);
            done_q      <= 1'b0;
            blocked_q   <= 1'b0;
            rom_index_q <= 13'd0;
`ifdef MAZE_GOAL_DETECT_EN
            goal_q      <= 1'b0;
            goal_seen_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            k_q         <= k_d;
            px_q        <= px_d;
            py_q        <= py_d;
            done_q      <= done_d;
            blocked_q   <= blocked_d;
            rom_index_q <= rom_index_d;
`ifdef MAZE_GOAL_DETECT_EN
            goal_q      <= goal_d;
            goal_seen_q <= goal_seen_d;
`endif
        end
    end

    maze_pix_overlay u_overlay (
        .clk       (clk),
        .reset     (reset),
        .pix_req   (pix_req),
        .pix_index (pix_index),
        .rom_data  (rom_data),
        .player_x  (px_q),
        .player_y  (py_q),
        .pix_data  (pix_data),
        .pix_valid (pix_valid)
    );

    assign rom_index    = rom_index_d;
    assign move_busy    = busy_s;
    assign move_done    = done_q;
    assign move_blocked = blocked_q;
    assign player_x     = px_q;
    assign player_y     = py_q;
`ifdef MAZE_GOAL_DETECT_EN
    assign goal_reached = goal_q;
`else
    assign goal_reached = 1'b0;
`endif

endmodule
